ysyx_24080006_axi_arb: RTL and testbench

- Two-master, one-slave AXI4 arbiter that shares the single memory/peripheral bus between the instruction fetch unit (IFU, read-only) and the load/store unit in the EX stage (LSU, read and write).
- Sits between the core's `ysyx_24080006_axi` master ports and the SoC/xbar slave port.
- Grants exactly one transaction at a time, forwards the granted master's channels, and releases on the final response.
- Provides round-robin or fixed-priority arbitration and a sticky timeout watchdog.

---
 rtl/ysyx_24080006_axi_arb_if.sv | 59 +++++
 rtl/ysyx_24080006_axi_arb.sv | 217 +++++++++++++++++++++
 tb/tb_ysyx_24080006_axi_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24080006_axi_arb_if.sv
// AXI4 channel bundle shared by the core masters, the arbiter and the SoC slave.
// Ports (signals):
//   AR : arvalid, arready, araddr[31:0], arid[3:0], arlen[7:0], arsize[2:0], arburst[1:0]
//   R  : rvalid, rready, rresp[1:0], rdata[31:0], rlast, rid[3:0]
//   AW : awvalid, awready, awaddr[31:0], awid[3:0], awlen[7:0], awsize[2:0], awburst[1:0]
//   W  : wvalid, wready, wdata[31:0], wstrb[3:0], wlast
//   B  : bvalid, bready, bresp[1:0], bid[3:0]
// modport master drives the request side, modport slave drives the response side.
interface ysyx_24080006_axi;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
               awvalid, awaddr, awid, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready,
        input  arready, rvalid, rresp, rdata, rlast, rid,
               awready, wready, bvalid, bresp, bid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
               awvalid, awaddr, awid, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rresp, rdata, rlast, rid,
               awready, wready, bvalid, bresp, bid
    );
endinterface

// File: rtl/ysyx_24080006_axi_arb.sv
// Two-master / one-slave AXI4 arbiter: IFU (read only) and LSU (read/write)
// share one downstream bus, one transaction at a time.
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   ifu          IFU read master (AW/W/B responses tied off)
//   lsu          LSU read/write master
//   mem          shared downstream slave
//   grant[1:0]   registered one-hot grant, [0]=IFU, [1]=LSU, 00 when idle
//   err_timeout  sticky, busy state lasted TIMEOUT cycles
//   err_rid      sticky, R beat id differed from the forwarded arid
//
// state  | meaning
// IDLE   | no grant, nothing forwarded, sample requests
// RD_IFU | IFU AR/R forwarded until the rlast beat
// RD_LSU | LSU AR/R forwarded until the rlast beat
// WR_LSU | LSU AW/W/B forwarded until the B handshake
module ysyx_24080006_axi_arb #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    ysyx_24080006_axi.slave         ifu,
    ysyx_24080006_axi.slave         lsu,
    ysyx_24080006_axi.master        mem,
    output logic [1:0]              grant,
    output logic                    err_timeout,
    output logic                    err_rid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } state_t;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic            last_ifu;
    logic            ifu_req;
    logic            lsu_req;
    logic            pick_lsu;
    logic            ar_hs;
    logic            r_hs;
    logic [3:0]      arid_q;
    logic [3:0]      rid_exp;
    logic [WD_W-1:0] wdog;
    logic            unused_ifu_wr;

    // The IFU never writes; its write-side request signals are intentionally ignored.
    assign unused_ifu_wr = ^{ifu.awvalid, ifu.awaddr, ifu.awid, ifu.awlen, ifu.awsize,
                             ifu.awburst, ifu.wvalid, ifu.wdata, ifu.wstrb, ifu.wlast,
                             ifu.bready};

    assign ifu_req = ifu.arvalid;
    assign lsu_req = lsu.arvalid | lsu.awvalid;
    // On a tie the master that did not win last time is chosen, unless LSU has fixed priority.
    assign pick_lsu = lsu_req && (!ifu_req || (FIXED_PRIO != 0) || last_ifu);

    assign ar_hs   = mem.arvalid && mem.arready;
    assign r_hs    = mem.rvalid && mem.rready;
    // An R beat cannot legally precede its AR, but use the live arid if both land together.
    assign rid_exp = ar_hs ? mem.arid : arid_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ifu_req || lsu_req) begin
                    if (pick_lsu) state_nxt = lsu.arvalid ? RD_LSU : WR_LSU;
                    else          state_nxt = RD_IFU;
                end
            end
            RD_IFU, RD_LSU: begin
                if (mem.rvalid && mem.rready && mem.rlast) state_nxt = IDLE;
            end
            WR_LSU: begin
                if (mem.bvalid && mem.bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= 2'b00;
            last_ifu <= 1'b0;
            arid_q   <= 4'd0;
            err_rid  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= {(state_nxt == RD_LSU) || (state_nxt == WR_LSU), state_nxt == RD_IFU};
            if (state == IDLE && state_nxt != IDLE) last_ifu <= (state_nxt == RD_IFU);
            if (ar_hs) arid_q <= mem.arid;
            if (r_hs && (mem.rid != rid_exp)) err_rid <= 1'b1;
        end
    end

    // Busy-cycle watchdog; saturates at TIMEOUT and never forces the FSM out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog        <= '0;
            err_timeout <= 1'b0;
        end else if (state == IDLE) begin
            wdog <= '0;
        end else if ((TIMEOUT != 0) && (wdog != WD_MAX)) begin
            wdog <= wdog + WD_W'(1);
            if (wdog == WD_LAST) err_timeout <= 1'b1;
        end
    end

    always_comb begin
        ifu.arready = 1'b0;
        ifu.rvalid  = 1'b0;
        ifu.rresp   = 2'b00;
        ifu.rdata   = 32'd0;
        ifu.rlast   = 1'b0;
        ifu.rid     = 4'd0;
        ifu.awready = 1'b0;
        ifu.wready  = 1'b0;
        ifu.bvalid  = 1'b0;
        ifu.bresp   = 2'b00;
        ifu.bid     = 4'd0;

        lsu.arready = 1'b0;
        lsu.rvalid  = 1'b0;
        lsu.rresp   = 2'b00;
        lsu.rdata   = 32'd0;
        lsu.rlast   = 1'b0;
        lsu.rid     = 4'd0;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bvalid  = 1'b0;
        lsu.bresp   = 2'b00;
        lsu.bid     = 4'd0;

        mem.arvalid = 1'b0;
        mem.araddr  = 32'd0;
        mem.arid    = 4'd0;
        mem.arlen   = 8'd0;
        mem.arsize  = 3'd0;
        mem.arburst = 2'b00;
        mem.rready  = 1'b0;
        mem.awvalid = 1'b0;
        mem.awaddr  = 32'd0;
        mem.awid    = 4'd0;
        mem.awlen   = 8'd0;
        mem.awsize  = 3'd0;
        mem.awburst = 2'b00;
        mem.wvalid  = 1'b0;
        mem.wdata   = 32'd0;
        mem.wstrb   = 4'd0;
        mem.wlast   = 1'b0;
        mem.bready  = 1'b0;

        case (state)
            RD_IFU: begin
                mem.arvalid = ifu.arvalid;
                mem.araddr  = ifu.araddr;
                mem.arid    = ifu.arid;
                mem.arlen   = ifu.arlen;
                mem.arsize  = ifu.arsize;
                mem.arburst = ifu.arburst;
                ifu.arready = mem.arready;
                ifu.rvalid  = mem.rvalid;
                ifu.rresp   = mem.rresp;
                ifu.rdata   = mem.rdata;
                ifu.rlast   = mem.rlast;
                ifu.rid     = mem.rid;
                mem.rready  = ifu.rready;
            end
            RD_LSU: begin
                mem.arvalid = lsu.arvalid;
                mem.araddr  = lsu.araddr;
                mem.arid    = lsu.arid;
                mem.arlen   = lsu.arlen;
                mem.arsize  = lsu.arsize;
                mem.arburst = lsu.arburst;
                lsu.arready = mem.arready;
                lsu.rvalid  = mem.rvalid;
                lsu.rresp   = mem.rresp;
                lsu.rdata   = mem.rdata;
                lsu.rlast   = mem.rlast;
                lsu.rid     = mem.rid;
                mem.rready  = lsu.rready;
            end
            WR_LSU: begin
                mem.awvalid = lsu.awvalid;
                mem.awaddr  = lsu.awaddr;
                mem.awid    = lsu.awid;
                mem.awlen   = lsu.awlen;
                mem.awsize  = lsu.awsize;
                mem.awburst = lsu.awburst;
                lsu.awready = mem.awready;
                mem.wvalid  = lsu.wvalid;
                mem.wdata   = lsu.wdata;
                mem.wstrb   = lsu.wstrb;
                mem.wlast   = lsu.wlast;
                lsu.wready  = mem.wready;
                lsu.bvalid  = mem.bvalid;
                lsu.bresp   = mem.bresp;
                lsu.bid     = mem.bid;
                mem.bready  = lsu.bready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_24080006_axi_arb.sv
// Self-checking bench for ysyx_24080006_axi_arb: a table of arbitration
// vectors plus directed multi-cycle sequences. A second instance with
// FIXED_PRIO=1 covers the fixed-priority tie.
module tb_ysyx_24080006_axi_arb;

    logic       clock;
    logic       rst_n;
    logic [1:0] grant_a, grant_b;
    logic       tmo_a, tmo_b, rid_a, rid_b;
    int         tests;
    int         fails;

    ysyx_24080006_axi ifu_a ();
    ysyx_24080006_axi lsu_a ();
    ysyx_24080006_axi mem_a ();
    ysyx_24080006_axi ifu_b ();
    ysyx_24080006_axi lsu_b ();
    ysyx_24080006_axi mem_b ();

    ysyx_24080006_axi_arb #(.FIXED_PRIO(0), .TIMEOUT(16)) dut_a (
        .clock(clock), .reset(rst_n), .ifu(ifu_a), .lsu(lsu_a), .mem(mem_a),
        .grant(grant_a), .err_timeout(tmo_a), .err_rid(rid_a)
    );

    ysyx_24080006_axi_arb #(.FIXED_PRIO(1), .TIMEOUT(4096)) dut_b (
        .clock(clock), .reset(rst_n), .ifu(ifu_b), .lsu(lsu_b), .mem(mem_b),
        .grant(grant_b), .err_timeout(tmo_b), .err_rid(rid_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       i_ar;
        logic       l_ar;
        logic       l_aw;
        logic [1:0] g;
        logic       wr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic init_a();
        ifu_a.arvalid = 0; ifu_a.araddr = 0; ifu_a.arid = 0; ifu_a.arlen = 0;
        ifu_a.arsize = 3'd2; ifu_a.arburst = 2'b01; ifu_a.rready = 1;
        ifu_a.awvalid = 0; ifu_a.awaddr = 0; ifu_a.awid = 0; ifu_a.awlen = 0;
        ifu_a.awsize = 0; ifu_a.awburst = 0; ifu_a.wvalid = 0; ifu_a.wdata = 0;
        ifu_a.wstrb = 0; ifu_a.wlast = 0; ifu_a.bready = 1;
        lsu_a.arvalid = 0; lsu_a.araddr = 0; lsu_a.arid = 0; lsu_a.arlen = 0;
        lsu_a.arsize = 3'd2; lsu_a.arburst = 2'b01; lsu_a.rready = 1;
        lsu_a.awvalid = 0; lsu_a.awaddr = 0; lsu_a.awid = 0; lsu_a.awlen = 0;
        lsu_a.awsize = 3'd2; lsu_a.awburst = 2'b01; lsu_a.wvalid = 0; lsu_a.wdata = 0;
        lsu_a.wstrb = 0; lsu_a.wlast = 1; lsu_a.bready = 1;
        mem_a.arready = 0; mem_a.rvalid = 0; mem_a.rresp = 0; mem_a.rdata = 0;
        mem_a.rlast = 0; mem_a.rid = 0; mem_a.awready = 0; mem_a.wready = 0;
        mem_a.bvalid = 0; mem_a.bresp = 0; mem_a.bid = 0;
    endtask

    task automatic init_b();
        ifu_b.arvalid = 0; ifu_b.araddr = 0; ifu_b.arid = 0; ifu_b.arlen = 0;
        ifu_b.arsize = 0; ifu_b.arburst = 0; ifu_b.rready = 1;
        ifu_b.awvalid = 0; ifu_b.awaddr = 0; ifu_b.awid = 0; ifu_b.awlen = 0;
        ifu_b.awsize = 0; ifu_b.awburst = 0; ifu_b.wvalid = 0; ifu_b.wdata = 0;
        ifu_b.wstrb = 0; ifu_b.wlast = 0; ifu_b.bready = 1;
        lsu_b.arvalid = 0; lsu_b.araddr = 0; lsu_b.arid = 0; lsu_b.arlen = 0;
        lsu_b.arsize = 0; lsu_b.arburst = 0; lsu_b.rready = 1;
        lsu_b.awvalid = 0; lsu_b.awaddr = 0; lsu_b.awid = 0; lsu_b.awlen = 0;
        lsu_b.awsize = 0; lsu_b.awburst = 0; lsu_b.wvalid = 0; lsu_b.wdata = 0;
        lsu_b.wstrb = 0; lsu_b.wlast = 0; lsu_b.bready = 1;
        mem_b.arready = 0; mem_b.rvalid = 0; mem_b.rresp = 0; mem_b.rdata = 0;
        mem_b.rlast = 0; mem_b.rid = 0; mem_b.awready = 0; mem_b.wready = 0;
        mem_b.bvalid = 0; mem_b.bresp = 0; mem_b.bid = 0;
    endtask

    // AR handshake, then a single rlast beat; ends with the arbiter back in IDLE.
    task automatic complete_read(input logic [1:0] who);
        mem_a.arready = 1;
        step();
        mem_a.arready = 0;
        if (who == 2'b01) ifu_a.arvalid = 0;
        else              lsu_a.arvalid = 0;
        mem_a.rvalid = 1;
        mem_a.rlast  = 1;
        mem_a.rid    = 0;
        step();
        mem_a.rvalid = 0;
        mem_a.rlast  = 0;
    endtask

    task automatic complete_write();
        mem_a.awready = 1;
        mem_a.wready  = 1;
        step();
        lsu_a.awvalid = 0;
        lsu_a.wvalid  = 0;
        mem_a.awready = 0;
        mem_a.wready  = 0;
        mem_a.bvalid  = 1;
        step();
        mem_a.bvalid  = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        init_a();
        init_b();

        //           i_ar  l_ar  l_aw  grant  write
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0};

        #12;
        chk("rst_grant", {30'd0, grant_a}, 32'd0);
        chk("rst_err_timeout", {31'd0, tmo_a}, 32'd0);
        chk("rst_err_rid", {31'd0, rid_a}, 32'd0);
        chk("rst_mem_arvalid", {31'd0, mem_a.arvalid}, 32'd0);
        chk("rst_ifu_arready", {31'd0, ifu_a.arready}, 32'd0);
        rst_n = 1'b1;
        step();

        // Arbitration table, starting from last_grant = LSU.
        for (int i = 0; i < 9; i++) begin
            ifu_a.arvalid = vecs[i].i_ar;
            lsu_a.arvalid = vecs[i].l_ar;
            lsu_a.awvalid = vecs[i].l_aw;
            lsu_a.wvalid  = vecs[i].l_aw;
            step();
            chk($sformatf("vec%0d_grant", i), {30'd0, grant_a}, {30'd0, vecs[i].g});
            chk($sformatf("vec%0d_mem_arvalid", i), {31'd0, mem_a.arvalid},
                {31'd0, (vecs[i].g != 2'b00) && !vecs[i].wr});
            chk($sformatf("vec%0d_mem_awvalid", i), {31'd0, mem_a.awvalid}, {31'd0, vecs[i].wr});
            if (vecs[i].g != 2'b00) begin
                if (vecs[i].wr) complete_write();
                else            complete_read(vecs[i].g);
            end
            ifu_a.arvalid = 0;
            lsu_a.arvalid = 0;
            lsu_a.awvalid = 0;
            lsu_a.wvalid  = 0;
        end

        // IFU single read with data return.
        step();
        mem_a.arready = 1;
        ifu_a.araddr  = 32'h3000_0000;
        ifu_a.arvalid = 1;
        #1;
        chk("ifu_rd_idle_arready", {31'd0, ifu_a.arready}, 32'd0);
        step();
        chk("ifu_rd_grant", {30'd0, grant_a}, 32'd1);
        chk("ifu_rd_araddr", mem_a.araddr, 32'h3000_0000);
        chk("ifu_rd_arready", {31'd0, ifu_a.arready}, 32'd1);
        step();
        ifu_a.arvalid = 0;
        mem_a.arready = 0;
        mem_a.rvalid  = 1;
        mem_a.rlast   = 1;
        mem_a.rdata   = 32'hDEAD_BEEF;
        #1;
        chk("ifu_rd_rvalid", {31'd0, ifu_a.rvalid}, 32'd1);
        chk("ifu_rd_rdata", ifu_a.rdata, 32'hDEAD_BEEF);
        chk("lsu_rd_rvalid_idle", {31'd0, lsu_a.rvalid}, 32'd0);
        step();
        mem_a.rvalid = 0;
        mem_a.rlast  = 0;
        chk("ifu_rd_release", {30'd0, grant_a}, 32'd0);

        // Tie right after reset: IFU first, LSU served next.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        ifu_a.arvalid = 1;
        lsu_a.arvalid = 1;
        step();
        chk("tie_first_ifu", {30'd0, grant_a}, 32'd1);
        complete_read(2'b01);
        chk("tie_bubble", {30'd0, grant_a}, 32'd0);
        step();
        chk("tie_then_lsu", {30'd0, grant_a}, 32'd2);
        complete_read(2'b10);

        // LSU store, W accepted two cycles before AW, IFU stalled.
        lsu_a.awaddr  = 32'h0F00_0010;
        lsu_a.wdata   = 32'h1234_5678;
        lsu_a.wstrb   = 4'hF;
        lsu_a.awvalid = 1;
        lsu_a.wvalid  = 1;
        step();
        chk("st_grant", {30'd0, grant_a}, 32'd2);
        chk("st_awaddr", mem_a.awaddr, 32'h0F00_0010);
        chk("st_wdata", mem_a.wdata, 32'h1234_5678);
        chk("st_wstrb", {28'd0, mem_a.wstrb}, 32'hF);
        ifu_a.arvalid = 1;
        mem_a.arready = 1;
        mem_a.wready  = 1;
        #1;
        chk("st_wready", {31'd0, lsu_a.wready}, 32'd1);
        chk("st_ifu_stall0", {31'd0, ifu_a.arready}, 32'd0);
        chk("st_mem_arvalid", {31'd0, mem_a.arvalid}, 32'd0);
        step();
        lsu_a.wvalid = 0;
        mem_a.wready = 0;
        step();
        mem_a.awready = 1;
        #1;
        chk("st_awready", {31'd0, lsu_a.awready}, 32'd1);
        step();
        lsu_a.awvalid = 0;
        mem_a.awready = 0;
        mem_a.bvalid  = 1;
        #1;
        chk("st_bvalid", {31'd0, lsu_a.bvalid}, 32'd1);
        chk("st_ifu_stall1", {31'd0, ifu_a.arready}, 32'd0);
        chk("st_grant_hold", {30'd0, grant_a}, 32'd2);
        step();
        mem_a.bvalid  = 0;
        mem_a.arready = 0;
        chk("st_release", {30'd0, grant_a}, 32'd0);
        step();
        chk("st_ifu_next", {30'd0, grant_a}, 32'd1);
        complete_read(2'b01);

        // IFU 4-beat burst with LSU read pending.
        ifu_a.arlen   = 8'd3;
        ifu_a.arvalid = 1;
        step();
        chk("burst_grant", {30'd0, grant_a}, 32'd1);
        lsu_a.arvalid = 1;
        mem_a.arready = 1;
        step();
        ifu_a.arvalid = 0;
        mem_a.arready = 0;
        for (int b = 0; b < 4; b++) begin
            mem_a.rvalid = 1;
            mem_a.rlast  = (b == 3);
            mem_a.rdata  = 32'h100 + b;
            step();
            if (b < 3) begin
                chk($sformatf("burst_hold%0d", b), {30'd0, grant_a}, 32'd1);
                chk($sformatf("burst_lsu_stall%0d", b), {31'd0, lsu_a.arready}, 32'd0);
            end
        end
        mem_a.rvalid = 0;
        mem_a.rlast  = 0;
        ifu_a.arlen  = 8'd0;
        chk("burst_bubble", {30'd0, grant_a}, 32'd0);
        step();
        chk("burst_lsu_grant", {30'd0, grant_a}, 32'd2);
        complete_read(2'b10);
        chk("rid_clean", {31'd0, rid_a}, 32'd0);

        // IFU read with arid=0 answered with rid=2.
        ifu_a.arid    = 4'd0;
        ifu_a.arvalid = 1;
        step();
        mem_a.arready = 1;
        step();
        ifu_a.arvalid = 0;
        mem_a.arready = 0;
        mem_a.rvalid  = 1;
        mem_a.rlast   = 1;
        mem_a.rid     = 4'd2;
        step();
        mem_a.rvalid = 0;
        mem_a.rlast  = 0;
        mem_a.rid    = 4'd0;
        chk("rid_err_set", {31'd0, rid_a}, 32'd1);
        step();
        step();
        chk("rid_err_sticky", {31'd0, rid_a}, 32'd1);
        chk("tmo_clean", {31'd0, tmo_a}, 32'd0);

        // Memory never answers: watchdog fires 16 cycles after the grant.
        ifu_a.arlen   = 8'd3;
        ifu_a.arvalid = 1;
        step();
        chk("tmo_grant", {30'd0, grant_a}, 32'd1);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 15) chk("tmo_not_yet", {31'd0, tmo_a}, 32'd0);
            if (k == 16) chk("tmo_set", {31'd0, tmo_a}, 32'd1);
        end
        step();
        chk("tmo_no_recovery", {30'd0, grant_a}, 32'd1);
        chk("tmo_sticky", {31'd0, tmo_a}, 32'd1);

        // Asynchronous reset in the middle of the stuck burst.
        #2;
        rst_n = 1'b0;
        mem_a.rvalid = 1;
        mem_a.rlast  = 1;
        ifu_a.arvalid = 0;
        #1;
        chk("arst_grant", {30'd0, grant_a}, 32'd0);
        chk("arst_mem_arvalid", {31'd0, mem_a.arvalid}, 32'd0);
        chk("arst_ifu_rvalid", {31'd0, ifu_a.rvalid}, 32'd0);
        chk("arst_err_timeout", {31'd0, tmo_a}, 32'd0);
        chk("arst_err_rid", {31'd0, rid_a}, 32'd0);
        #4;
        rst_n = 1'b1;
        step();
        chk("arst_no_stale_r", {31'd0, ifu_a.rvalid}, 32'd0);
        chk("arst_idle", {30'd0, grant_a}, 32'd0);
        mem_a.rvalid = 0;
        mem_a.rlast  = 0;

        // Fixed priority: LSU wins ties even when it won last time.
        ifu_b.arvalid = 1;
        lsu_b.arvalid = 1;
        step();
        chk("fix_tie0", {30'd0, grant_b}, 32'd2);
        lsu_b.arvalid = 0;
        mem_b.rvalid  = 1;
        mem_b.rlast   = 1;
        step();
        mem_b.rvalid  = 0;
        mem_b.rlast   = 0;
        lsu_b.arvalid = 1;
        step();
        chk("fix_tie1", {30'd0, grant_b}, 32'd2);
        lsu_b.arvalid = 0;
        mem_b.rvalid  = 1;
        mem_b.rlast   = 1;
        step();
        mem_b.rvalid = 0;
        mem_b.rlast  = 0;
        step();
        chk("fix_ifu_alone", {30'd0, grant_b}, 32'd1);
        ifu_b.arvalid = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
